// File: rtl/umi_putc_pkg.sv
// rtl/umi_putc_pkg.sv - shared constants for UMI character-print traffic
package umi_putc_pkg;

  localparam logic [4:0]  OPC_REQ_READ      = 5'h01;
  localparam logic [4:0]  OPC_REQ_WRITE     = 5'h03;
  localparam logic [4:0]  OPC_REQ_POSTED    = 5'h05;
  localparam logic [7:0]  CHAR_NEWLINE      = 8'h0A;
  localparam logic [63:0] PUTC_ADDR_DEFAULT = 64'h1000000;

  // A print is exactly a posted write landing on the sink address.
  function automatic logic putc_match(input logic [4:0]  opcode,
                                      input logic [63:0] dstaddr,
                                      input logic [63:0] putc_addr);
    return (opcode == OPC_REQ_POSTED) && (dstaddr == putc_addr);
  endfunction

endpackage

// File: rtl/umi_putc_fifo.sv
// rtl/umi_putc_fifo.sv - byte FIFO with wrap-bit pointers and occupancy output
module umi_putc_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [7:0]    push_data,
  output logic          full,
  input  logic          pop,
  output logic [7:0]    pop_data,
  output logic          empty,
  output logic [AW:0]   level
);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [7:0]  mem [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level    = wr_ptr - rd_ptr;
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is left unreset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/umi_putc_sink.sv
// rtl/umi_putc_sink.sv - UMI endpoint turning posted PUTC writes into a byte stream
module umi_putc_sink
  import umi_putc_pkg::*;
#(
  parameter int                    CMD_WIDTH  = 32,
  parameter int                    ADDR_WIDTH = 64,
  parameter int                    DATA_WIDTH = 128,
  parameter logic [ADDR_WIDTH-1:0] PUTC_ADDR  = ADDR_WIDTH'(PUTC_ADDR_DEFAULT),
  parameter int                    FIFO_DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         udev_req_valid,
  input  logic [CMD_WIDTH-1:0]         udev_req_cmd,
  input  logic [ADDR_WIDTH-1:0]        udev_req_dstaddr,
  input  logic [ADDR_WIDTH-1:0]        udev_req_srcaddr,
  input  logic [DATA_WIDTH-1:0]        udev_req_data,
  output logic                         udev_req_ready,
  output logic                         char_valid,
  output logic [7:0]                   char_data,
  input  logic                         char_ready,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output logic [15:0]                  line_count,
  output logic [15:0]                  drop_count
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic reset_q;
  logic full;
  logic empty;
  logic accept;
  logic match;
  logic push;
  logic pop;
  logic unused_req_bits;

  // Holds ready low for one cycle after reset release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) reset_q <= 1'b1;
    else       reset_q <= 1'b0;
  end

  assign udev_req_ready = !reset_q && !full;
  assign accept         = udev_req_valid && udev_req_ready;
  assign match          = putc_match(udev_req_cmd[4:0], 64'(udev_req_dstaddr), 64'(PUTC_ADDR));
  assign push           = accept && match;
  assign char_valid     = !empty;
  assign pop            = char_valid && char_ready;

  assign unused_req_bits = ^{udev_req_cmd[CMD_WIDTH-1:5], udev_req_srcaddr,
                             udev_req_data[DATA_WIDTH-1:8]};

  umi_putc_fifo #(
    .DEPTH (FIFO_DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (udev_req_data[7:0]),
    .full      (full),
    .pop       (pop),
    .pop_data  (char_data),
    .empty     (empty),
    .level     (fifo_level)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_count <= 16'h0000;
    end else if (accept && !match && (drop_count != 16'hFFFF)) begin
      drop_count <= drop_count + 16'd1;
    end
  end

  // Newlines are counted as they leave, so the count tracks console output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line_count <= 16'h0000;
    end else if (pop && (char_data == CHAR_NEWLINE) && (line_count != 16'hFFFF)) begin
      line_count <= line_count + 16'd1;
    end
  end

endmodule
